frame_deframer: RTL and testbench

- Sits directly downstream of the sync-header demodulator.
- Consumes the serial payload bit stream the demodulator emits after a sync match, LSB-first per byte.
- Parses the frame as LEN byte, then LEN payload bytes, then 16-bit CRC; delivers payload bytes in parallel and reports CRC status.
- Returns the demodulator to header search by pulsing fsc_end.

---
 rtl/frame_deframer_pkg.sv | 25 ++
 rtl/frame_deframer_crc16.sv | 40 ++++
 rtl/frame_deframer.sv | 167 ++++++++++++++++
 tb/tb_frame_deframer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/frame_deframer_pkg.sv
// Shared definitions for the frame deframer: FSM encoding, CRC-16 constants
// and the single-bit reflected CCITT LFSR step.
package frame_deframer_pkg;

  localparam int          LEN_W    = 8;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h8408;

  typedef enum logic [1:0] {
    S_LEN = 2'd0,
    S_PAY = 2'd1,
    S_CRC = 2'd2,
    S_END = 2'd3
  } state_t;

  // Right-shift LFSR: the feedback bit is the outgoing LSB xor the new bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic        bit_in,
                                             input logic [15:0] poly = CRC_POLY);
    logic fb;
    fb = crc[0] ^ bit_in;
    return (crc >> 1) ^ (fb ? poly : 16'h0000);
  endfunction

endpackage

// File: rtl/frame_deframer_crc16.sv
// Bit-serial CRC-16 register with synchronous init and enable; shared with
// the modulator-side CRC generator.
module crc16_serial
  import frame_deframer_pkg::*;
#(
  parameter logic [15:0] INIT = frame_deframer_pkg::CRC_INIT,
  parameter logic [15:0] POLY = frame_deframer_pkg::CRC_POLY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // init wins over en so a new frame always starts from a clean register.
  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = INIT;
    end else if (en) begin
      crc_d = crc16_step(crc_q, bit_in, POLY);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/frame_deframer.sv
// Frame deframer: parses LEN, LEN payload bytes and a 16-bit CRC from an
// LSB-first serial stream, emitting bytes in parallel and a frame status.
module frame_deframer
  import frame_deframer_pkg::*;
#(
  parameter int          MAX_LEN  = 64,
  parameter logic [15:0] CRC_INIT = frame_deframer_pkg::CRC_INIT,
  parameter logic [15:0] CRC_POLY = frame_deframer_pkg::CRC_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             data_in_valid,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_done,
  output logic             crc_ok,
  output logic             len_err,
  output logic             fsc_end,
  output state_t           state_dbg
);

  // Stream contract: valid-only, no backpressure. A bit transfers on any
  // posedge with data_in_valid = 1 outside S_END; strobes last one cycle.
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  state_t           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [6:0]       shift_q, shift_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             crc_ok_q, crc_ok_d;
  logic             len_err_q, len_err_d;
  logic             fsc_end_q, fsc_end_d;

  logic             accept, byte_done, crc_init, crc_en;
  logic [7:0]       new_byte;
  logic [LEN_W-1:0] byte_cnt_inc;
  logic [15:0]      crc;

  crc16_serial #(.INIT(CRC_INIT), .POLY(CRC_POLY)) u_crc (
    .clk    (clk),
    .rst    (rst),
    .init   (crc_init),
    .en     (crc_en),
    .bit_in (data_in),
    .crc    (crc)
  );

  always_comb begin
    accept       = data_in_valid && (state_q != S_END);
    byte_done    = accept && (bit_cnt_q == 3'd7);
    new_byte     = {data_in, shift_q};
    byte_cnt_inc = byte_cnt_q + 8'd1;

    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    frame_len_d  = frame_len_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    frame_done_d = 1'b0;
    crc_ok_d     = 1'b0;
    len_err_d    = 1'b0;
    fsc_end_d    = 1'b0;
    crc_init     = 1'b0;
    crc_en       = 1'b0;

    if (accept) begin
      shift_d   = new_byte[7:1];
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    case (state_q)
      S_LEN: begin
        if (byte_done) begin
          frame_len_d = new_byte;
          if (new_byte == 8'd0 || new_byte > MAX_LEN_V) begin
            state_d      = S_END;
            len_err_d    = 1'b1;
            frame_done_d = 1'b1;
            fsc_end_d    = 1'b1;
          end else begin
            crc_init   = 1'b1;
            byte_cnt_d = '0;
            state_d    = S_PAY;
          end
        end
      end
      S_PAY: begin
        crc_en = accept;
        if (byte_done) begin
          byte_out_d   = new_byte;
          byte_valid_d = 1'b1;
          byte_cnt_d   = byte_cnt_inc;
          if (byte_cnt_inc == frame_len_q) begin
            byte_cnt_d = '0;
            state_d    = S_CRC;
          end
        end
      end
      S_CRC: begin
        crc_en = accept;
        if (byte_done) begin
          if (byte_cnt_q == 8'd1) begin
            // Residue must be zero once both CRC bytes have been shifted in.
            state_d      = S_END;
            frame_done_d = 1'b1;
            fsc_end_d    = 1'b1;
            crc_ok_d     = (crc16_step(crc, data_in, CRC_POLY) == 16'h0000);
          end else begin
            byte_cnt_d = 8'd1;
          end
        end
      end
      S_END: begin
        state_d    = S_LEN;
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
      end
      default: state_d = S_LEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_LEN;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      frame_len_q  <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      crc_ok_q     <= 1'b0;
      len_err_q    <= 1'b0;
      fsc_end_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      frame_len_q  <= frame_len_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      frame_done_q <= frame_done_d;
      crc_ok_q     <= crc_ok_d;
      len_err_q    <= len_err_d;
      fsc_end_q    <= fsc_end_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign frame_len  = frame_len_q;
  assign frame_done = frame_done_q;
  assign crc_ok     = crc_ok_q;
  assign len_err    = len_err_q;
  assign fsc_end    = fsc_end_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_frame_deframer.sv
// Directed bench for frame_deframer: serial frames in, payload bytes and
// frame status checked against expectation queues filled by the driver.
module tb_frame_deframer;
  import frame_deframer_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_in = 1'b0;
  logic       data_in_valid = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic [7:0] frame_len;
  logic       frame_done;
  logic       crc_ok;
  logic       len_err;
  logic       fsc_end;
  state_t     state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  frame_deframer #(.MAX_LEN(64)) dut (
    .clk           (clk),
    .rst           (rst_n),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .byte_out      (byte_out),
    .byte_valid    (byte_valid),
    .frame_len     (frame_len),
    .frame_done    (frame_done),
    .crc_ok        (crc_ok),
    .len_err       (len_err),
    .fsc_end       (fsc_end),
    .state_dbg     (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [9:0] exp_frame_q[$];  // {len, crc_ok, len_err}
  logic [7:0] pay_q[$];
  int         last_byte_cyc = 0;
  int         last_gap = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = (r >> 1) ^ (fb ? 16'h8408 : 16'h0000);
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b, input bit gapped);
    data_in       = b;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    if (gapped) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gapped);
    for (int i = 0; i < 8; i++) send_bit(b[i], gapped);
  endtask

  task automatic send_frame(input logic [7:0] len, input bit gapped,
                            input bit corrupt, input bit idle_after);
    logic [15:0] c;
    logic [15:0] crc_tx;
    logic [15:0] res;
    if (len == 8'd0 || len > 8'd64) begin
      exp_frame_q.push_back({len, 1'b0, 1'b1});
      send_byte(len, gapped);
    end else begin
      c = 16'hFFFF;
      foreach (pay_q[i]) c = crc_byte(c, pay_q[i]);
      crc_tx = corrupt ? (c ^ 16'h0001) : c;
      res    = crc_byte(crc_byte(c, crc_tx[7:0]), crc_tx[15:8]);
      foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
      exp_frame_q.push_back({len, (res == 16'h0000), 1'b0});
      send_byte(len, gapped);
      foreach (pay_q[i]) send_byte(pay_q[i], gapped);
      send_byte(crc_tx[7:0], gapped);
      send_byte(crc_tx[15:8], gapped);
    end
    if (!gapped) begin
      check("done_latency", frame_done, 1'b1);
      check("fsc_latency", fsc_end, 1'b1);
      if (idle_after) begin
        @(negedge clk);
        check("fsc_one_cycle", fsc_end, 1'b0);
      end
    end
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    logic [9:0] ef;
    if (byte_valid) begin
      if (exp_q.size() == 0) check("byte_unexpected", 1, 0);
      else check("byte_out", byte_out, exp_q.pop_front());
      last_gap      = cyc - last_byte_cyc;
      last_byte_cyc = cyc;
    end
    if (frame_done) begin
      if (exp_frame_q.size() == 0) check("frame_unexpected", 1, 0);
      else begin
        ef = exp_frame_q.pop_front();
        check("frame_len", frame_len, ef[9:2]);
        check("crc_ok", crc_ok, ef[1]);
        check("len_err", len_err, ef[0]);
      end
    end else begin
      check("status_qualified", {crc_ok, len_err}, 2'b00);
    end
    check("fsc_eq_done", fsc_end, frame_done);
  end

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_byte_out", byte_out, 8'h00);
    check("rst_byte_valid", byte_valid, 1'b0);
    check("rst_frame_len", frame_len, 8'h00);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_fsc_end", fsc_end, 1'b0);
    check("rst_state", state_dbg, S_LEN);
    rst_n = 1'b1;
    @(negedge clk);

    // Good frame
    pay_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frame(8'd9, 1'b0, 1'b0, 1'b1);
    check("frame_len_held", frame_len, 8'd9);

    // Corrupted CRC
    send_frame(8'd9, 1'b0, 1'b1, 1'b1);

    // Length errors
    pay_q.delete();
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'h41, 1'b0, 1'b0, 1'b1);

    // LEN = MAX_LEN with random payload
    for (int i = 0; i < 64; i++) pay_q.push_back(8'($urandom_range(0, 255)));
    send_frame(8'd64, 1'b0, 1'b0, 1'b1);

    // Gapped input
    pay_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frame(8'd9, 1'b1, 1'b0, 1'b1);
    check("gapped_byte_spacing", last_gap, 16);

    // Back-to-back with a garbage bit during S_END
    send_frame(8'd9, 1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    pay_q = {8'hA5};
    send_frame(8'd1, 1'b0, 1'b0, 1'b1);
    check("b2b_frame_len", frame_len, 8'd1);

    // Reset mid-frame after four payload bytes
    pay_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_byte(8'd9, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(pay_q[i]);
      send_byte(pay_q[i], 1'b0);
    end
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_byte_valid", byte_valid, 1'b0);
    check("midrst_byte_out", byte_out, 8'h00);
    check("midrst_frame_len", frame_len, 8'h00);
    check("midrst_frame_done", frame_done, 1'b0);
    check("midrst_state", state_dbg, S_LEN);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(8'd9, 1'b0, 1'b0, 1'b1);

    repeat (5) @(negedge clk);
    check("bytes_outstanding", exp_q.size(), 0);
    check("frames_outstanding", exp_frame_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
